// File: rtl/axi_def.sv
// Shared AXI-3 read definitions: response codes, burst types, status codes.
package axi_def;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] LOCK_NORMAL = 2'b00;

    localparam logic [1:0] STAT_READY = 2'd0;
    localparam logic [1:0] STAT_BUSY  = 2'd1;
    localparam logic [1:0] STAT_OK    = 2'd2;
    localparam logic [1:0] STAT_ERROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rd_state_t;

    function automatic int axsize(input int bus_width);
        return $clog2(bus_width / 8);
    endfunction

endpackage

// File: rtl/axi_rd_burst_calc.sv
// Burst length: min of max burst, remaining beats and beats left in the 4 KB page.
module axi_rd_burst_calc
    import axi_def::*;
#(
    parameter int AXI_RD_COUNT_WIDTH   = 16,
    parameter int AXI_RD_BUS_WIDTH     = 32,
    parameter int AXI_RD_MAX_BURST_LEN = 16
) (
    input  logic [11:0]                   page_offset,
    input  logic [AXI_RD_COUNT_WIDTH-1:0] remaining,
    output logic [3:0]                    ar_len
);

    localparam int SIZE = axsize(AXI_RD_BUS_WIDTH);

    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [4:0]  len;

    always_comb begin
        page_bytes = 13'h1000 - {1'b0, page_offset};
        page_beats = page_bytes >> SIZE;
        len = 5'(AXI_RD_MAX_BURST_LEN);
        if (32'(remaining) < 32'(len))
            len = 5'(remaining);
        if (page_beats < 13'(len))
            len = page_beats[4:0];
        ar_len = 4'(len - 5'd1);
    end

endmodule

// File: rtl/axi_rd_stream.sv
// AXI-3 read master streaming a multi-burst transfer to a valid/ready output.
// Optional AXI_RD_ID_CHECK_EN flags beats whose r_id differs from the request id.
module axi_rd_stream
    import axi_def::*;
#(
    parameter int AXI_RD_ID_WIDTH      = 8,
    parameter int AXI_RD_ADDR_WIDTH    = 32,
    parameter int AXI_RD_BUS_WIDTH     = 32,
    parameter int AXI_RD_MAX_BURST_LEN = 16,
    parameter int AXI_RD_COUNT_WIDTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AXI_RD_ID_WIDTH-1:0]    id,
    input  logic [AXI_RD_ADDR_WIDTH-1:0]  addr,
    input  logic [AXI_RD_COUNT_WIDTH-1:0] beats,
    input  logic [3:0]                    cache,
    input  logic [2:0]                    prot,
    input  logic [4:0]                    user,
    output logic [1:0]                    status,
    output logic [AXI_RD_BUS_WIDTH-1:0]   m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [AXI_RD_ID_WIDTH-1:0]    ar_id,
    output logic [AXI_RD_ADDR_WIDTH-1:0]  ar_addr,
    output logic [3:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    output logic [1:0]                    ar_lock,
    output logic [3:0]                    ar_cache,
    output logic [2:0]                    ar_prot,
    output logic [4:0]                    ar_user,
    output logic                          ar_valid,
    input  logic                          ar_ready,
    input  logic [AXI_RD_ID_WIDTH-1:0]    r_id,
    input  logic [AXI_RD_BUS_WIDTH-1:0]   r_data,
    input  logic                          r_last,
    input  logic [1:0]                    r_resp,
    input  logic                          r_valid,
    output logic                          r_ready
);

    localparam int AW   = AXI_RD_ADDR_WIDTH;
    localparam int CW   = AXI_RD_COUNT_WIDTH;
    localparam int SIZE = axsize(AXI_RD_BUS_WIDTH);
    localparam logic [AW-1:0] ADDR_MASK = {AW{1'b1}} << SIZE;

    rd_state_t state, state_nx;

    logic [AW-1:0]              cur_addr;
    logic [CW-1:0]              remaining;
    logic [3:0]                 beat_cnt;
    logic [3:0]                 len_q;
    logic                       err;
    logic [AXI_RD_ID_WIDTH-1:0] id_q;
    logic [3:0]                 cache_q;
    logic [2:0]                 prot_q;
    logic [4:0]                 user_q;

    logic [3:0]    calc_len;
    logic [4:0]    len_p1;
    logic [AW-1:0] burst_bytes;
    logic          ar_hs;
    logic          r_hs;
    logic          burst_end;
    logic          last_beat;
    logic          id_err;
    logic          beat_err;

    axi_rd_burst_calc #(
        .AXI_RD_COUNT_WIDTH  (CW),
        .AXI_RD_BUS_WIDTH    (AXI_RD_BUS_WIDTH),
        .AXI_RD_MAX_BURST_LEN(AXI_RD_MAX_BURST_LEN)
    ) u_calc (
        .page_offset(cur_addr[11:0]),
        .remaining  (remaining),
        .ar_len     (calc_len)
    );

    assign ar_hs       = (state == ST_ADDR) && ar_ready;
    assign r_hs        = (state == ST_DATA) && r_valid && m_ready;
    assign burst_end   = r_hs && (beat_cnt == len_q);
    assign last_beat   = (remaining == CW'(1));
    assign len_p1      = {1'b0, len_q} + 5'd1;
    assign burst_bytes = AW'(len_p1) << SIZE;

`ifdef AXI_RD_ID_CHECK_EN
    assign id_err = (r_id != id_q);
`else
    logic unused_r_id;
    assign unused_r_id = ^r_id;
    assign id_err = 1'b0;
`endif

    // r_last is only a cross-check; the local counter decides burst end.
    assign beat_err = (r_resp >= RRESP_SLVERR)
                   || (r_last != (beat_cnt == len_q))
                   || id_err;

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        status   = STAT_READY;
        unique case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = (beats == '0) ? ST_DONE : ST_ADDR;
            end
            ST_ADDR: begin
                status   = STAT_BUSY;
                ar_valid = 1'b1;
                if (ar_ready)
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                status  = STAT_BUSY;
                r_ready = m_ready;
                m_valid = r_valid;
                m_last  = r_valid && last_beat;
                if (burst_end)
                    state_nx = last_beat ? ST_DONE : ST_ADDR;
            end
            ST_DONE: begin
                status   = err ? STAT_ERROR : STAT_OK;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            len_q     <= '0;
            err       <= 1'b0;
            id_q      <= '0;
            cache_q   <= '0;
            prot_q    <= '0;
            user_q    <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                cur_addr  <= addr & ADDR_MASK;
                remaining <= beats;
                beat_cnt  <= '0;
                err       <= 1'b0;
                id_q      <= id;
                cache_q   <= cache;
                prot_q    <= prot;
                user_q    <= user;
            end
            if (ar_hs) begin
                len_q    <= calc_len;
                beat_cnt <= '0;
            end
            if (r_hs) begin
                remaining <= remaining - CW'(1);
                beat_cnt  <= beat_cnt + 4'd1;
                if (beat_err)
                    err <= 1'b1;
                if (burst_end)
                    cur_addr <= cur_addr + burst_bytes;
            end
        end
    end

    assign m_data   = r_data;
    assign ar_id    = id_q;
    assign ar_addr  = cur_addr;
    assign ar_len   = calc_len;
    assign ar_size  = 3'(SIZE);
    assign ar_burst = BURST_INCR;
    assign ar_lock  = LOCK_NORMAL;
    assign ar_cache = cache_q;
    assign ar_prot  = prot_q;
    assign ar_user  = user_q;

endmodule

// File: tb/tb_axi_rd_stream.sv
// Directed bench for axi_rd_stream with a ready AXI-3 slave model.
module tb_axi_rd_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [15:0] beats;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [4:0]  user;
    logic [1:0]  status;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [7:0]  ar_id;
    logic [31:0] ar_addr;
    logic [3:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [1:0]  ar_lock;
    logic [3:0]  ar_cache;
    logic [2:0]  ar_prot;
    logic [4:0]  ar_user;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  r_id;
    logic [31:0] r_data;
    logic        r_last;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef AXI_RD_ID_CHECK_EN
    localparam logic [1:0] ID_EXP = 2'd3;
`else
    localparam logic [1:0] ID_EXP = 2'd2;
`endif

    axi_rd_stream dut (
        .clock(clock), .reset(reset), .start(start), .id(id),
        .addr(addr), .beats(beats), .cache(cache), .prot(prot),
        .user(user), .status(status), .m_data(m_data),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock),
        .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_user(ar_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .r_id(r_id),
        .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          beats;
        int          err_beat;
        int          id_beat;
        int          last_bad;
        int          stall_at;
        int          nar;
        logic [31:0] a0, a1, a2;
        int          l0, l1, l2;
        logic [1:0]  exp_st;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int ar_n = 0;
        logic [31:0] ar_a[3];
        int ar_l[3];
        int bidx = 0, bcnt = 0, blen = 0;
        int stall_left = 0, stall_cnt = 0;
        bit act = 0, stalled = 0, done = 0;
        bit ok_rr = 1, ok_mv = 1, ok_ol = 1, ok_d = 1, ok_l = 1, ok_at = 1;
        logic [1:0] fin = 2'bxx;
        for (int i = 0; i < 3; i++) begin
            ar_a[i] = '0;
            ar_l[i] = -1;
        end
        @(negedge clock);
        start = 1; addr = v.addr; beats = 16'(v.beats);
        id = 8'h5A; cache = 4'h3; prot = 3'h2; user = 5'h11;
        m_ready = 1; ar_ready = 0; r_valid = 0;
        @(posedge clock);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            start = 1; addr = 32'hDEAD_BEEC; beats = 16'd5;
            id = 8'hFF; cache = 0; prot = 0; user = 0;
            if (!stalled && act && bidx == v.stall_at) begin
                stall_left = 5;
                stalled = 1;
            end
            m_ready  = (stall_left == 0);
            ar_ready = 1;
            r_valid  = act;
            r_data   = 32'(bidx);
            r_last   = (bcnt == blen) != (bidx == v.last_bad);
            r_resp   = (bidx == v.err_beat) ? 2'b10 : 2'b00;
            r_id     = (bidx == v.id_beat) ? 8'h00 : 8'h5A;
            #1;
            if (status != 2'd1) begin
                fin = status;
                done = 1;
                break;
            end
            if (r_ready !== (act ? m_ready : 1'b0)) ok_rr = 0;
            if (m_valid !== act) ok_mv = 0;
            if (act && !r_ready) stall_cnt++;
            if (ar_valid && act) ok_ol = 0;
            if (ar_valid) begin
                if (ar_n < 3) begin
                    ar_a[ar_n] = ar_addr;
                    ar_l[ar_n] = int'(ar_len);
                end
                if (ar_size != 3'd2 || ar_burst != 2'b01 ||
                    ar_lock != 2'b00 || ar_id != 8'h5A ||
                    ar_cache != 4'h3 || ar_prot != 3'h2 ||
                    ar_user != 5'h11)
                    ok_at = 0;
                ar_n++;
                act = 1;
                blen = int'(ar_len);
                bcnt = 0;
            end else if (act && m_ready) begin
                if (m_data !== 32'(bidx)) ok_d = 0;
                if (m_last !== (bidx == v.beats - 1)) ok_l = 0;
                bidx++;
                if (bcnt == blen) act = 0;
                bcnt++;
            end
            if (stall_left > 0) stall_left--;
        end
        if (!done) chk({v.name, " timeout"}, 1, 0);
        chk({v.name, " status"}, 64'(fin), 64'(v.exp_st));
        chk({v.name, " beats"}, 64'(bidx), 64'(v.beats));
        chk({v.name, " ar count"}, 64'(ar_n), 64'(v.nar));
        if (v.nar > 0) begin
            chk({v.name, " ar0"}, {ar_a[0], 32'(ar_l[0])},
                {v.a0, 32'(v.l0)});
            chk({v.name, " ar attrs"}, 64'(ok_at), 1);
        end
        if (v.nar > 1)
            chk({v.name, " ar1"}, {ar_a[1], 32'(ar_l[1])},
                {v.a1, 32'(v.l1)});
        if (v.nar > 2)
            chk({v.name, " ar2"}, {ar_a[2], 32'(ar_l[2])},
                {v.a2, 32'(v.l2)});
        chk({v.name, " data"}, 64'(ok_d), 1);
        chk({v.name, " m_last"}, 64'(ok_l), 1);
        chk({v.name, " r_ready"}, 64'(ok_rr), 1);
        chk({v.name, " m_valid"}, 64'(ok_mv), 1);
        chk({v.name, " one outstanding"}, 64'(ok_ol), 1);
        chk({v.name, " stall cycles"}, 64'(stall_cnt),
            64'((v.stall_at >= 0) ? 5 : 0));
        @(negedge clock);
        start = 0; r_valid = 0; ar_ready = 0; m_ready = 1;
        #1;
        chk({v.name, " back to ready"}, {62'd0, status}, 0);
        chk({v.name, " idle ar_valid"}, 64'(ar_valid), 0);
    endtask

    initial begin
        vecs[0] = '{"burst40", 32'h1000, 40, -1, -1, -1, -1, 3,
                    32'h1000, 32'h1040, 32'h1080, 15, 15, 7, 2'd2};
        vecs[1] = '{"page4k", 32'h0FF8, 8, -1, -1, -1, -1, 2,
                    32'h0FF8, 32'h1000, 0, 1, 5, 0, 2'd2};
        vecs[2] = '{"zero", 32'h1000, 0, -1, -1, -1, -1, 0,
                    0, 0, 0, 0, 0, 0, 2'd2};
        vecs[3] = '{"slverr", 32'h2000, 20, 2, -1, -1, -1, 2,
                    32'h2000, 32'h2040, 0, 15, 3, 0, 2'd3};
        vecs[4] = '{"stall", 32'h3000, 10, -1, -1, -1, 4, 1,
                    32'h3000, 0, 0, 9, 0, 0, 2'd2};
        vecs[5] = '{"idchk", 32'h4000, 6, -1, 3, -1, -1, 1,
                    32'h4000, 0, 0, 5, 0, 0, ID_EXP};
        vecs[6] = '{"unaligned", 32'h1003, 2, -1, -1, -1, -1, 1,
                    32'h1000, 0, 0, 1, 0, 0, 2'd2};
        vecs[7] = '{"pageend", 32'h0FFC, 3, -1, -1, -1, -1, 2,
                    32'h0FFC, 32'h1000, 0, 0, 1, 0, 2'd2};
        vecs[8] = '{"lastbad", 32'h6000, 4, -1, -1, 1, -1, 1,
                    32'h6000, 0, 0, 3, 0, 0, 2'd3};
        vecs[9] = '{"single", 32'h5000, 1, -1, -1, -1, -1, 1,
                    32'h5000, 0, 0, 0, 0, 0, 2'd2};

        reset = 1; start = 0; id = 0; addr = 0; beats = 0;
        cache = 0; prot = 0; user = 0; m_ready = 0; ar_ready = 0;
        r_id = 0; r_data = 0; r_last = 0; r_resp = 0; r_valid = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset status", {62'd0, status}, 0);
        chk("reset ar_valid", 64'(ar_valid), 0);
        chk("reset r_ready", 64'(r_ready), 0);
        chk("reset m_valid", 64'(m_valid), 0);
        reset = 0; r_valid = 0;

        for (int i = 0; i < 9; i++)
            run(vecs[i]);

        // Abandon a transfer mid-burst with reset.
        @(negedge clock);
        start = 1; addr = 32'h7000; beats = 16'd8; id = 8'h5A;
        m_ready = 1; ar_ready = 0; r_valid = 0;
        @(negedge clock);
        start = 0; ar_ready = 1;
        #1;
        chk("midrst ar_valid", 64'(ar_valid), 1);
        @(negedge clock);
        ar_ready = 0; r_valid = 1; r_last = 0; r_resp = 0;
        #1;
        chk("midrst r_ready", 64'(r_ready), 1);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        #1;
        chk("midrst status", {62'd0, status}, 0);
        chk("midrst r_ready idle", 64'(r_ready), 0);
        chk("midrst m_valid idle", 64'(m_valid), 0);
        chk("midrst ar_valid idle", 64'(ar_valid), 0);
        r_valid = 0;

        run(vecs[9]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
